// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions for the BIOS serial RX/TX blocks.
package uart_pkg;
  typedef enum logic [2:0] {RX_HUNT, RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  output logic                   o_full,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             w_pop, w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_data;
  end
endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a byte FIFO with valid/ready output and sticky error flags.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clear_err,
  output logic       o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int H  = CLKS_PER_BIT / 2;

  uart_rx_state_t r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_bit, w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           r_sync1, r_sync2, w_rxs;
  logic           r_push, w_push_nxt, w_ferr_evt;
  logic           r_frame_err, r_overrun;
  logic           w_pop, w_full, w_ovr_evt, w_unused;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign w_rxs = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push_nxt  = 1'b0;
    w_ferr_evt  = 1'b0;
    case (r_state)
      RX_HUNT: begin
        if (!w_rxs) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
        end
      end
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == CW'(H - 1)) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'(UART_DATA_BITS - 1)) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_push_nxt  = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_ferr_evt  = 1'b1;
            w_state_nxt = RX_HUNT;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RX_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_HUNT;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_push  <= w_push_nxt;
    end
  end

  // r_shift holds the finished byte while r_push is high (it only moves in RX_DATA)
  assign w_pop     = o_valid & i_ready;
  assign w_ovr_evt = r_push & w_full & ~w_pop;

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_push),
    .i_push_data(r_shift),
    .o_full     (w_full),
    .i_pop      (w_pop),
    .o_head     (o_data),
    .o_valid    (o_valid),
    .o_count    (w_count)
  );

  // occupancy is not needed by the receiver itself
  assign w_unused = &{1'b0, w_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr_evt | (r_frame_err & ~i_clear_err);
      r_overrun   <= w_ovr_evt  | (r_overrun   & ~i_clear_err);
    end
  end

  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != RX_IDLE);
endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed-random bench for uart_rx_stream at 8 clocks per bit, 4-entry FIFO.
module tb_uart_rx_stream;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, i_rx, i_ready, i_clear_err;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] rcv[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_stream #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .i_clear_err(i_clear_err),
    .o_busy     (o_busy)
  );

  // consumer side: every accepted beat lands in rcv
  always @(negedge clk) begin
    #1;
    if (o_valid === 1'b1 && i_ready === 1'b1) rcv.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, rcv.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rcv.size(); i++)
      check($sformatf("%s_b%0d", tag, i), rcv[i], exp_q[i]);
  endtask

  // drive one frame starting at a falling clock edge, LSB first
  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic pulse_clear();
    i_clear_err = 1'b1;
    @(negedge clk);
    i_clear_err = 1'b0;
  endtask

  initial begin
    int first;
    logic [7:0] b, b2;

    i_rx = 1'b1; i_ready = 1'b0; i_clear_err = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    check("rst_busy", o_busy, 1);
    rst = 1'b0;
    repeat (CPB + 2) @(negedge clk);
    check("hunt_done_busy", o_busy, 0);

    // single frame: valid rises 80 edges after the start bit is driven
    i_ready = 1'b1; rcv.delete(); first = 0;
    fork
      send_frame(8'h07, 1'b1);
      for (int i = 1; i <= 80; i++) begin
        @(negedge clk);
        if (o_valid === 1'b1 && first == 0) first = i;
      end
    join
    check("t1_latency", first, 80);
    check("t1_data", o_data, 8'h07);
    @(negedge clk);
    check("t1_one_beat", o_valid, 0);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    repeat (4) @(negedge clk);
    exp_q = '{8'h07, b};
    check_stream("t1_stream");
    check("t1_ferr", o_frame_err, 0);
    check("t1_ovr", o_overrun, 0);

    // five frames into a stalled 4-deep FIFO: the fifth is dropped
    i_ready = 1'b0; rcv.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(b);
      send_frame(b, 1'b1);
      if (i == DEPTH - 1) begin
        @(negedge clk);
        check("t2_ovr_before", o_overrun, 0);
      end
    end
    repeat (4) @(negedge clk);
    check("t2_ovr", o_overrun, 1);
    check("t2_hold_valid", o_valid, 1);
    check("t2_hold_data", o_data, exp_q[0]);
    i_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_stream("t2_stream");
    check("t2_empty", o_valid, 0);
    pulse_clear();
    check("t2_ovr_clr", o_overrun, 0);

    // bad stop bit drops the byte, resync after 8 idle cycles, next byte ok
    rcv.delete();
    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_frame(b, 1'b0);
    check("t3_ferr", o_frame_err, 1);
    repeat (CPB) @(negedge clk);
    send_frame(b2, 1'b1);
    repeat (4) @(negedge clk);
    exp_q = '{b2};
    check_stream("t3_stream");
    check("t3_ferr_sticky", o_frame_err, 1);
    check("t3_ovr", o_overrun, 0);
    pulse_clear();
    check("t3_ferr_clr", o_frame_err, 0);
    check("t3_ovr_clr", o_overrun, 0);

    // 2-cycle glitch: busy for H cycles then back to idle
    rcv.delete();
    i_rx = 1'b0;
    repeat (2) @(negedge clk);
    i_rx = 1'b1;
    @(negedge clk);
    check("t4_busy_hi", o_busy, 1);
    repeat (4) @(negedge clk);
    check("t4_busy_lo", o_busy, 0);
    repeat (10) @(negedge clk);
    check("t4_no_beat", rcv.size(), 0);
    check("t4_ferr", o_frame_err, 0);

    // reset during data bit 4 with the line stuck low
    b = 8'($urandom);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      i_rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (18) @(negedge clk);
    check("t5_hunt_busy", o_busy, 1);
    check("t5_no_valid", o_valid, 0);
    i_rx = 1'b1;
    repeat (9) @(negedge clk);
    check("t5_hunt_hold", o_busy, 1);
    @(negedge clk);
    check("t5_idle", o_busy, 0);
    send_frame(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    exp_q = '{8'h01};
    check_stream("t5_stream");
    check("t5_ferr", o_frame_err, 0);

    // full FIFO: fifth push lands exactly on the first pop
    i_ready = 1'b0; rcv.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_frame(b, 1'b1);
      begin
        repeat (79) @(negedge clk);
        i_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("t6_ovr", o_overrun, 0);
    check_stream("t6_stream");
    check("t6_empty", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
